// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/owner enums and default widths for the DMEM port arbiter
package dmem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int WAIT_W = 8;
  typedef enum logic {ARB, LOCK} arb_state_t;
  typedef enum logic {OWN_C, OWN_L} owner_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter (clk, rst_n, inc_i, clr_i -> cnt_o), clear wins over increment
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one DMEM port between core (c_*) and loader (l_*) with starvation bound, lock bursts, 1-cycle read return and stall count
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);
  arb_state_t state_q, state_d;
  owner_t rd_owner_q, rd_owner_d;
  logic rd_pending_q, rd_pending_d;
  logic [DATA_W-1:0] c_rdata_q, l_rdata_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic l_win;
  always_comb begin
    l_win = (state_q == LOCK) ? l_req : l_req && (!c_req || wait_cnt == WAIT_W'(MAX_WAIT));
    l_gnt = reset && l_win;
    c_gnt = reset && c_req && !l_win && state_q == ARB;
    c_stall = reset && c_req && !c_gnt;
    mem_en = c_gnt || l_gnt;
    mem_we = c_gnt ? c_we : l_gnt && l_we;
    mem_addr = c_gnt ? c_addr : l_gnt ? l_addr : '0;
    mem_wdata = c_gnt ? c_wdata : l_gnt ? l_wdata : '0;
    state_d = (state_q == ARB) ? ((l_gnt && l_lock) ? LOCK : ARB) : (l_lock ? LOCK : ARB);
    rd_pending_d = mem_en && !mem_we;
    rd_owner_d = rd_pending_d ? (l_gnt ? OWN_L : OWN_C) : rd_owner_q;
    c_rvalid = rd_pending_q && rd_owner_q == OWN_C;
    l_rvalid = rd_pending_q && rd_owner_q == OWN_L;
    c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
    l_rdata = l_rvalid ? mem_rdata : l_rdata_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ARB;
      rd_owner_q <= OWN_C;
      rd_pending_q <= 1'b0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_owner_q <= rd_owner_d;
      rd_pending_q <= rd_pending_d;
      c_rdata_q <= c_rdata;
      l_rdata_q <= l_rdata;
    end
  sat_counter #(.W(WAIT_W), .LIMIT(WAIT_W'(MAX_WAIT))) u_wait (
    .clk(clk), .rst_n(reset), .inc_i(l_req && !l_gnt), .clr_i(l_gnt || !l_req), .cnt_o(wait_cnt)
  );
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(reset), .inc_i(c_stall), .clr_i(1'b0), .cnt_o(stall_cnt)
  );
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port data memory of the single-cycle RISC-V core between two requesters: the core's load/store path (port C) and an external loader/debug master (port L). It sits between the core's ALU-address/store-data outputs and the DMEM macro. It grants one access per cycle, stalls the core when the loader owns the memory, and returns read data one cycle after acceptance. It enforces bounded loader starvation and supports a locked loader burst for program/data download.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width
MAX_WAIT, 4, loader wait cycles before it preempts the core (1..255)
CNT_W, 16, width of stall statistics counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
c_req  in  1  core access request (MemRead|MemWrite)
c_we  in  1  core write enable
c_addr  in  ADDR_W  core address (ALUOut)
c_wdata  in  DATA_W  core store data (Readdata2)
c_gnt  out  1  core request accepted this cycle
c_stall  out  1  c_req & ~c_gnt; freezes PC/regfile write
c_rvalid  out  1  core read data valid
c_rdata  out  DATA_W  core read data
l_req  in  1  loader access request
l_we  in  1  loader write enable
l_lock  in  1  loader requests exclusive burst ownership
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  loader request accepted this cycle
l_rvalid  out  1  loader read data valid
l_rdata  out  DATA_W  loader read data
mem_en  out  1  DMEM access enable
mem_we  out  1  DMEM write enable
mem_addr  out  ADDR_W  DMEM address
mem_wdata  out  DATA_W  DMEM write data
mem_rdata  in  DATA_W  DMEM read data, valid 1 cycle after mem_en & ~mem_we
stall_cnt  out  CNT_W  saturating count of cycles with c_stall=1

Behaviour:
- Reset (reset=0, async): state=ARB, wait_cnt=0, rd_pending=0, rd_owner=C, stall_cnt=0; c_rvalid=l_rvalid=0, c_rdata=l_rdata=0; while reset=0 all gnt/mem_en/mem_we/c_stall forced 0.
- Grant is combinational same cycle; access accepted when req&gnt at rising clk. At most one gnt high per cycle. mem_* driven combinationally from the winner; mem_en=c_gnt|l_gnt, mem_we=winner's we; mem_addr/mem_wdata=0 when no grant.
- FSM states: ARB, LOCK.
- ARB: only c_req -> C; only l_req -> L; both -> C unless wait_cnt==MAX_WAIT, then L. If L granted with l_lock=1 -> LOCK.
- LOCK: L owns memory; l_gnt=l_req; c_gnt=0. Exit to ARB on the cycle l_lock=0 (that cycle still arbitrated as LOCK; ARB applies from next cycle). l_req=0 in LOCK: no access, still locked.
- wait_cnt: +1 each cycle l_req&~l_gnt, saturates at MAX_WAIT; cleared on any l_gnt or l_req=0.
- Reads: accepted read sets rd_pending=1, rd_owner=winner next cycle; in that cycle owner's rvalid=1, rdata=mem_rdata registered? No: rdata=mem_rdata passed through, rvalid registered (latency 1 from accept). Non-owner rdata holds its last value.
- Writes: complete at accept edge; no rvalid.
- Back-to-back reads from alternating owners each return in order, one per cycle.
- stall_cnt: +1 per cycle c_stall=1, saturates at all-ones.
- Reset asserted mid-read: pending rvalid dropped, never issued.

Decomposition:
- Shared package dmem_arb_pkg: typedef enum {ARB, LOCK} arb_state_t; typedef enum {OWN_C, OWN_L} owner_t; default widths.
- One sub-module natural: sat_counter (parameterised width/limit, inc, clr) used for wait_cnt and stall_cnt.

Test Plan:
- Reset: hold reset=0 with c_req=l_req=1 -> all gnt=0, mem_en=0, stall_cnt=0; release -> c_gnt=1 first cycle.
- Core only: c_req=1 read addr 0x10, mem returns 0xDEADBEEF -> c_gnt same cycle, c_rvalid=1 next cycle, c_rdata=0xDEADBEEF, l_rvalid=0.
- Contention, MAX_WAIT=4: c_req, l_req held 1 -> core granted 4 cycles, loader granted cycle 5, core again cycle 6; stall_cnt=1.
- Lock burst: l_req=l_lock=1 writes 8 words 0x0..0x1C, c_req=1 -> l_gnt 8 cycles, c_stall=1 throughout, stall_cnt=8; l_lock=0 -> core granted next cycle.
- Alternating reads C@0x4 then L@0x8 -> c_rvalid then l_rvalid on consecutive cycles with matching data.
- Reset mid-read: accept core read, assert reset before next edge -> c_rvalid never asserts.
